// File: rtl/mul_dsp_arbiter.sv
// mul_dsp_arbiter
// Shares one pipelined DSP multiplier (fixed LAT-cycle latency, no stall)
// among NREQ requesters. One operand pair is accepted per cycle, registered
// onto the multiplier inputs, and tagged with the requester id in a shift
// register that tracks the multiplier pipe so each product returns with its id.
//
// Build option: define MUL_ARB_FIXED_PRIO_EN for fixed priority (lowest valid
// index wins, no round-robin pointer). Default is round-robin.
module mul_dsp_arbiter #(
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*N-1:0]          req_a,
    input  logic [NREQ*N-1:0]          req_b,
    output logic [NREQ-1:0]            req_ready,
    output logic [N-1:0]               mul_a,
    output logic [N-1:0]               mul_b,
    input  logic [2*N-1:0]             mul_p,
    output logic                       rsp_valid,
    output logic [IDW-1:0]             rsp_id,
    output logic [2*N-1:0]             rsp_p,
    output logic [$clog2(LAT+2)-1:0]   inflight
);

    localparam int CNTW = $clog2(LAT+2);

    logic                w_found;
    logic [IDW-1:0]      w_grantId;
    logic [NREQ-1:0]     w_grantOneHot;
    logic                w_xfer;
    logic [CNTW-1:0]     w_inflight;

    logic [N-1:0]        r_mulA;
    logic [N-1:0]        r_mulB;
    logic [LAT:0]        r_tagV;
    logic [IDW-1:0]      r_tagId [0:LAT];

`ifdef MUL_ARB_FIXED_PRIO_EN

    // Fixed priority: the lowest-indexed valid requester wins
    always_comb begin
        w_found   = 1'b0;
        w_grantId = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[k]) begin
                w_found   = 1'b1;
                w_grantId = IDW'(k);
            end
        end
    end

`else

    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      w_cand;

    // Round-robin: scan from the requester after the last grant, first valid wins
    always_comb begin
        w_found   = 1'b0;
        w_grantId = '0;
        w_cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found   = 1'b1;
                w_grantId = w_cand;
            end
        end
    end

    // Remember the last granted id; reset to NREQ-1 so requester 0 goes first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= IDW'(NREQ-1);
        end else if (w_xfer) begin
            r_ptr <= w_grantId;
        end
    end

`endif

    // Turn the winning id into a one-hot grant, suppressed entirely during reset
    always_comb begin
        w_grantOneHot            = '0;
        w_grantOneHot[w_grantId] = 1'b1;
        w_xfer                   = w_found & ~rst;
        req_ready                = w_xfer ? w_grantOneHot : '0;
    end

    // Capture the granted operand pair onto the multiplier inputs; hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mulA <= '0;
            r_mulB <= '0;
        end else if (w_xfer) begin
            r_mulA <= req_a[w_grantId*N +: N];
            r_mulB <= req_b[w_grantId*N +: N];
        end
    end

    // Tag pipe one stage deeper than the multiplier so the id lines up with mul_p
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tagV <= '0;
            for (int k = 0; k <= LAT; k++) begin
                r_tagId[k] <= '0;
            end
        end else begin
            r_tagV <= {r_tagV[LAT-1:0], w_xfer};
            if (w_xfer) begin
                r_tagId[0] <= w_grantId;
            end
            for (int k = 1; k <= LAT; k++) begin
                r_tagId[k] <= r_tagId[k-1];
            end
        end
    end

    // Count live tags, including the one presenting on the response bus
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k <= LAT; k++) begin
            w_inflight = w_inflight + CNTW'(r_tagV[k]);
        end
    end

    assign mul_a     = r_mulA;
    assign mul_b     = r_mulB;
    assign rsp_valid = r_tagV[LAT];
    assign rsp_id    = r_tagId[LAT];
    assign rsp_p     = mul_p;
    assign inflight  = w_inflight;

endmodule

// File: tb/tb_mul_dsp_arbiter.sv
// tb_mul_dsp_arbiter
// Directed bench for mul_dsp_arbiter with a 3-stage registered multiplier model.
// Honors MUL_ARB_FIXED_PRIO_EN to select the expected grant order.
module tb_mul_dsp_arbiter;

    localparam int N    = 16;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 3;

`ifdef MUL_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      reqValid;
    logic [NREQ*N-1:0]    reqA;
    logic [NREQ*N-1:0]    reqB;
    logic [NREQ-1:0]      reqReady;
    logic [N-1:0]         mulA;
    logic [N-1:0]         mulB;
    logic [2*N-1:0]       mulP;
    logic                 rspValid;
    logic [IDW-1:0]       rspId;
    logic [2*N-1:0]       rspP;
    logic [2:0]           inflight;

    logic [2*N-1:0]       p1, p2, p3;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        int          reqIdx;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] expP;
    } vec_t;

    vec_t vecs [5];

    mul_dsp_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_a     (reqA),
        .req_b     (reqB),
        .req_ready (reqReady),
        .mul_a     (mulA),
        .mul_b     (mulB),
        .mul_p     (mulP),
        .rsp_valid (rspValid),
        .rsp_id    (rspId),
        .rsp_p     (rspP),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    // Three-cycle multiplier: operands sampled on an edge, product out three edges later
    always_ff @(posedge clk) begin
        p1 <= 32'(mulA) * 32'(mulB);
        p2 <= p1;
        p3 <= p2;
    end
    assign mulP = p3;

    function automatic logic [63:0] placeAt(input int idx, input logic [15:0] val);
        return 64'(val) << (idx * 16);
    endfunction

    task automatic applyStimulus(input logic [3:0] v, input logic [63:0] a, input logic [63:0] b);
        reqValid = v;
        reqA     = a;
        reqB     = b;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Response bus check; id and product only matter when a response is expected
    task automatic expectRsp(input string name, input logic expValid, input int expId, input logic [31:0] expP);
        checkOutput({name, " rsp_valid"}, 64'(rspValid), 64'(expValid));
        if (expValid) begin
            checkOutput({name, " rsp_id"}, 64'(rspId), 64'(expId));
            checkOutput({name, " rsp_p"}, 64'(rspP), 64'(expP));
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'b0, 64'b0, 64'b0);
        nextCycle();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0, 16'd3,    16'd5,    32'd15};
        vecs[1] = '{2, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{1, 16'h0000, 16'h1234, 32'h0};
        vecs[3] = '{3, 16'h8000, 16'h0002, 32'h00010000};
        vecs[4] = '{1, 16'h00FF, 16'h0101, 32'h0000FFFF};

        // Reset with every requester asking: nothing may be granted
        rst = 1'b1;
        applyStimulus(4'hF, 64'h0004_0003_0002_0001, 64'h0001_0001_0001_0001);
        @(negedge clk);
        checkOutput("ready during reset", 64'(reqReady), 64'h0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(4'b0, 64'b0, 64'b0);
        @(negedge clk);
        checkOutput("reset rsp_valid", 64'(rspValid), 64'h0);
        checkOutput("reset rsp_id", 64'(rspId), 64'h0);
        checkOutput("reset inflight", 64'(inflight), 64'h0);
        checkOutput("reset mul_a", 64'(mulA), 64'h0);
        nextCycle();

        // Single requests: grant in the issue cycle, response exactly four cycles later
        for (int v = 0; v < 5; v++) begin
            for (int t = 0; t <= 5; t++) begin
                if (t == 0) begin
                    applyStimulus(4'(1) << vecs[v].reqIdx,
                                  placeAt(vecs[v].reqIdx, vecs[v].a),
                                  placeAt(vecs[v].reqIdx, vecs[v].b));
                end else begin
                    applyStimulus(4'b0, 64'b0, 64'b0);
                end
                @(negedge clk);
                if (t == 0) begin
                    checkOutput($sformatf("vec%0d ready", v), 64'(reqReady), 64'(4'(1) << vecs[v].reqIdx));
                end
                expectRsp($sformatf("vec%0d t%0d", v, t), (t == 4), vecs[v].reqIdx, vecs[v].expP);
                nextCycle();
            end
        end

        // All four requesters continuously valid for five cycles
        doReset();
        for (int t = 0; t <= 8; t++) begin
            int expGrant;
            int expId;
            applyStimulus((t < 5) ? 4'hF : 4'h0, 64'h0004_0003_0002_0001, 64'h0100_0100_0100_0100);
            @(negedge clk);
            expGrant = FIXED ? 0 : (t % 4);
            checkOutput($sformatf("all4 t%0d ready", t), 64'(reqReady),
                        (t < 5) ? 64'(4'(1) << expGrant) : 64'h0);
            expId = FIXED ? 0 : ((t - 4) % 4);
            expectRsp($sformatf("all4 t%0d", t), (t >= 4), expId, 32'((expId + 1) * 32'h100));
            if (t == 4) begin
                checkOutput("all4 inflight peak", 64'(inflight), 64'd4);
            end
            nextCycle();
        end

        // Two issues followed by a one-cycle reset: both results must vanish
        doReset();
        applyStimulus(4'b0010, placeAt(1, 16'd5), placeAt(1, 16'd6));
        @(negedge clk);
        checkOutput("rstmid c0 ready", 64'(reqReady), 64'b0010);
        nextCycle();
        applyStimulus(4'b0100, placeAt(2, 16'd7), placeAt(2, 16'd8));
        @(negedge clk);
        checkOutput("rstmid c1 ready", 64'(reqReady), 64'b0100);
        nextCycle();
        rst = 1'b1;
        applyStimulus(4'hF, 64'h0004_0003_0002_0001, 64'h0001_0001_0001_0001);
        @(negedge clk);
        checkOutput("rstmid c2 ready", 64'(reqReady), 64'h0);
        nextCycle();
        rst = 1'b0;
        for (int t = 3; t <= 8; t++) begin
            applyStimulus(4'b0, 64'b0, 64'b0);
            @(negedge clk);
            checkOutput($sformatf("rstmid c%0d rsp_valid", t), 64'(rspValid), 64'h0);
            checkOutput($sformatf("rstmid c%0d inflight", t), 64'(inflight), 64'h0);
            nextCycle();
        end
        for (int t = 9; t <= 15; t++) begin
            if (t <= 10) begin
                applyStimulus((t == 9) ? 4'b0011 : 4'b0010,
                              placeAt(0, 16'd9) | placeAt(1, 16'd10),
                              placeAt(0, 16'd9) | placeAt(1, 16'd11));
            end else begin
                applyStimulus(4'b0, 64'b0, 64'b0);
            end
            @(negedge clk);
            if (t == 9)  checkOutput("rstmid c9 ready", 64'(reqReady), 64'b0001);
            if (t == 10) checkOutput("rstmid c10 ready", 64'(reqReady), 64'b0010);
            if (t >= 13) begin
                expectRsp($sformatf("rstmid c%0d", t), (t != 15), t - 13, (t == 13) ? 32'd81 : 32'd110);
            end
            nextCycle();
        end

        // Lone requester 3 granted three cycles in a row
        doReset();
        for (int t = 0; t <= 7; t++) begin
            if (t < 3) begin
                applyStimulus(4'b1000, placeAt(3, 16'(t + 2)), placeAt(3, 16'd7));
            end else begin
                applyStimulus(4'b0, 64'b0, 64'b0);
            end
            @(negedge clk);
            if (t < 3) begin
                checkOutput($sformatf("solo3 t%0d ready", t), 64'(reqReady), 64'b1000);
            end
            expectRsp($sformatf("solo3 t%0d", t), (t >= 4 && t <= 6), 3, 32'((t - 2) * 7));
            nextCycle();
        end

        // Requesters 0 and 2 continuously valid: alternate, or 0 always under fixed priority
        doReset();
        for (int t = 0; t < 4; t++) begin
            applyStimulus(4'b0101, placeAt(0, 16'd1) | placeAt(2, 16'd2),
                                   placeAt(0, 16'd1) | placeAt(2, 16'd2));
            @(negedge clk);
            checkOutput($sformatf("pair t%0d ready", t), 64'(reqReady),
                        (FIXED || (t % 2 == 0)) ? 64'b0001 : 64'b0100);
            nextCycle();
        end
        applyStimulus(4'b0, 64'b0, 64'b0);
        for (int t = 0; t < 6; t++) nextCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
